// File: rtl/reg_file_8x16.sv
// reg_file_8x16: 2**ADDR_W x WIDTH register file with two combinational read
// ports, one clocked write port, a never-bypassed debug read port and an
// optional write-to-read bypass. Register 0 is hardwired to zero.
module reg_file_8x16 #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [WIDTH-1:0]  rd_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs_q [Depth];
  logic             wr_live;

  // A write is live only outside reset and never for register 0.
  assign wr_live = wr_en && !reset && (wr_addr != '0);

  // Storage: async clear of every entry, then clocked writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_live) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Read port 1: zero in reset or for r0, bypass on address match, else stored value.
  always_comb begin
    rd_data1 = '0;
    if (reset || (rd_addr1 == '0)) begin
      rd_data1 = '0;
    end else if ((BYPASS != 0) && wr_live && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
    end else begin
      rd_data1 = regs_q[rd_addr1];
    end
  end

  // Read port 2: same resolution as port 1, evaluated independently.
  always_comb begin
    rd_data2 = '0;
    if (reset || (rd_addr2 == '0)) begin
      rd_data2 = '0;
    end else if ((BYPASS != 0) && wr_live && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_data;
    end else begin
      rd_data2 = regs_q[rd_addr2];
    end
  end

  // Debug port: stored contents only, never bypassed.
  always_comb begin
    dbg_data = '0;
    if (!reset && (dbg_addr != '0)) begin
      dbg_data = regs_q[dbg_addr];
    end
  end

endmodule
